// File: rtl/multicycle_seq.sv
// multicycle_seq: FETCH/DECODE/EXEC/MEM/WB sequencer that issues PC, IR, RF and data RAM strobes
module multicycle_seq #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_sup, r_illegal, r_bus_err;
    logic [CNT_W-1:0]   r_instret;
    logic               w_ld, w_st, w_br, w_legal, w_timeout, w_retire;

    assign w_ld    = opcode == 7'b0000011;
    assign w_st    = opcode == 7'b0100011;
    assign w_br    = opcode == 7'b1100011;
    assign w_legal = opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                    7'b1100011, 7'b1100111, 7'b1101111, 7'b0110111};
    // a timeout is only real when the matching ready is still low on the last allowed cycle
    assign w_timeout = r_cnt == CW'(TIMEOUT - 1) &&
                       ((r_state == FETCH && !imem_ready) || (r_state == MEM && !dmem_ready));
    assign w_retire  = (r_state == WB && !r_sup) || (r_state == MEM && w_st && dmem_ready);

    // next state and strobes; every strobe is held low while reset is asserted
    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req = !rst;
                ir_we    = !rst && imem_ready;
                w_next   = imem_ready ? DECODE : FETCH;
            end
            DECODE: w_next = w_legal ? EXEC : WB;
            EXEC:   w_next = (w_ld || w_st) ? MEM : WB;
            MEM: begin
                dmem_req = !rst;
                dmem_we  = !rst && w_st;
                pc_we    = !rst && ((w_st && dmem_ready) || w_timeout);
                w_next   = dmem_ready ? (w_st ? FETCH : WB) : (w_timeout ? FETCH : MEM);
            end
            WB: begin
                pc_we  = !rst;
                rf_we  = !rst && !r_sup && !w_st && !w_br;
                w_next = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

    // state, wait counter, suppress flag, pulses and retired count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_cnt     <= '0;
            r_sup     <= 1'b0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_next != r_state || w_timeout || !(r_state == FETCH || r_state == MEM)) ? '0 : r_cnt + 1'b1;
            r_sup     <= (r_state == DECODE) ? !w_legal : r_sup;
            r_illegal <= r_state == DECODE && !w_legal;
            r_bus_err <= w_timeout;
            r_instret <= w_retire ? r_instret + 1'b1 : r_instret;
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign instret = r_instret;
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: directed checks of the multicycle sequencer with TIMEOUT=16 and a 4-bit retire counter
module tb_multicycle_seq;
    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       imem_ready, dmem_ready;
    logic [2:0] state;
    logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, illegal, bus_err;
    logic [3:0] instret;
    int         errs = 0;
    int         checks = 0;
    int         bad;

    multicycle_seq #(.TIMEOUT(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .state(state), .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_we(pc_we), .illegal(illegal), .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = OP_ALU; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_instret", 32'(instret), 0);
        check("rst_pulses", {30'd0, illegal, bus_err}, 0);
        check("rst_no_strobe", 32'(imem_req), 0);
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        check("alu_fetch_ir_we", {30'd0, imem_req, ir_we}, 3);
        cyc(); check("alu_decode", 32'(state), 1);
        cyc(); check("alu_exec", 32'(state), 2);
        cyc(); check("alu_wb", {29'd0, state}, 4);
        check("alu_wb_strobes", {30'd0, rf_we, pc_we}, 3);
        cyc(); check("alu_back_fetch", 32'(state), 0);
        check("alu_instret", 32'(instret), 1);
        opcode = OP_LD;
        cyc(); cyc(); cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready = 1'b1;
            #1;
            check("ld_mem_state", 32'(state), 3);
            check("ld_mem_req_we", {30'd0, dmem_req, dmem_we}, 2);
            if (i < 3) cyc();
        end
        cyc(); dmem_ready = 1'b0; #1;
        check("ld_wb", {29'd0, state}, 4);
        check("ld_rf_we", 32'(rf_we), 1);
        cyc(); check("ld_back_fetch", 32'(state), 0);
        check("ld_instret", 32'(instret), 2);
        opcode = OP_ST;
        cyc(); cyc(); cyc(); dmem_ready = 1'b1; #1;
        check("st_mem", 32'(state), 3);
        check("st_strobes", {29'd0, dmem_we, pc_we, rf_we}, 6);
        cyc(); dmem_ready = 1'b0; #1;
        check("st_back_fetch", 32'(state), 0);
        check("st_instret", 32'(instret), 3);
        opcode = OP_BR;
        cyc(); cyc(); cyc();
        check("br_wb", {29'd0, state}, 4);
        check("br_strobes", {30'd0, pc_we, rf_we}, 2);
        cyc(); check("br_instret", 32'(instret), 4);
        opcode = OP_BAD;
        cyc(); check("ill_no_pulse_yet", 32'(illegal), 0);
        cyc(); check("ill_wb", {29'd0, state}, 4);
        check("ill_pulse", 32'(illegal), 1);
        check("ill_strobes", {30'd0, pc_we, rf_we}, 2);
        cyc(); check("ill_pulse_gone", 32'(illegal), 0);
        check("ill_instret", 32'(instret), 4);
        imem_ready = 1'b0; dmem_ready = 1'b1; #1;
        check("dmem_ready_ignored", {29'd0, dmem_req, dmem_we, pc_we}, 0);
        dmem_ready = 1'b0;
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            cyc();
            if (state != 3'd0 || pc_we) bad++;
            if (k % 16 == 15 || k % 16 == 0) check("if_bus_err", 32'(bus_err), (k % 16 == 0) ? 1 : 0);
        end
        check("if_timeout_state_pc", 32'(bad), 0);
        imem_ready = 1'b1; opcode = OP_LD;
        cyc(); cyc(); cyc();
        bad = 0;
        for (int j = 0; j < 16; j++) begin
            if (state != 3'd3 || rf_we || (j < 15 && pc_we)) bad++;
            if (j == 15) check("dm_timeout_pc_we", 32'(pc_we), 1);
            else cyc();
        end
        check("dm_wait_ok", 32'(bad), 0);
        cyc(); check("dm_bus_err", 32'(bus_err), 1);
        check("dm_back_fetch", 32'(state), 0);
        check("dm_instret", 32'(instret), 4);
        opcode = OP_ST;
        cyc(); cyc(); cyc();
        check("rst_mid_mem", 32'(state), 3);
        rst = 1'b1; #1;
        check("rst_cycle_no_req", {30'd0, dmem_req, pc_we}, 0);
        cyc(); rst = 1'b0;
        check("rst_mid_state", 32'(state), 0);
        check("rst_mid_instret", 32'(instret), 0);
        opcode = OP_ALU; #1;
        for (int i = 0; i < 16; i++) begin
            repeat (4) cyc();
            check("wrap_instret", 32'(instret), (i + 1) % 16);
        end
        check("wrap_state", 32'(state), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multi-cycle sequencer for the RV32 core. Steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
- Generates the write-enables and memory-request strobes for PC, IR, register file and data RAM.
- Datapath select fields (NPC_op, ALU_op, SEXT_op, ALU_B_sel, RF_WD_sel, PC_sel) stay with the combinational decoder. This block only decides *when* each state element updates.
- Instruction and data memories connect through req/ready handshakes with a bounded wait.

Parameters:
- TIMEOUT, 16, max cycles a request may wait for ready before abort (>=2)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- opcode  input  7  IR[6:0]; valid and stable from DECODE until the next FETCH completes
- imem_ready  input  1  instruction memory data valid this cycle
- dmem_ready  input  1  data memory access complete this cycle
- state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- imem_req  output  1  instruction fetch request
- ir_we  output  1  load IR from instruction memory
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (store)
- rf_we  output  1  register file write strobe
- pc_we  output  1  PC <= next PC
- illegal  output  1  one-cycle pulse, unsupported opcode
- bus_err  output  1  one-cycle pulse, handshake timeout
- instret  output  CNT_W  retired-instruction count

Behaviour:
- **Clock and reset.** One clock, clk. Reset rst is synchronous and active-high.
  - Reset takes effect at the next clk edge: state=FETCH, wait counter=0, instret=0, illegal=0, bus_err=0.
  - Reset mid-instruction abandons the instruction. No strobe is issued in the reset cycle.
- **Output timing.**
  - imem_req, ir_we, dmem_req, dmem_we, rf_we and pc_we are combinational from state, opcode and ready.
  - illegal and bus_err are registered pulses, high exactly one cycle after the triggering edge.
- **Supported opcodes.** 0110011, 0010011, 0000011 (load), 0100011 (store), 1100011 (branch), 1100111 (jalr), 1101111 (jal), 0110111 (lui). Any other opcode is illegal.
- **FETCH**
  - imem_req=1.
  - If imem_ready=1: ir_we=1, go to DECODE.
  - If no ready by the TIMEOUT-th waiting cycle: bus_err, stay in FETCH, counter cleared (retry same PC, no pc_we).
- **DECODE**
  - Always one cycle, no strobes.
  - Illegal opcode: set illegal, go to WB with the suppress flag set.
  - Otherwise go to EXEC.
- **EXEC**
  - One cycle, no strobes.
  - Load or store: go to MEM. Anything else: go to WB.
- **MEM**
  - dmem_req=1; dmem_we=1 only for store.
  - If dmem_ready=1: load goes to WB; store goes to FETCH with pc_we=1 in that cycle and is retired.
  - On timeout: bus_err, instruction aborted, pc_we=1, go to FETCH, not retired.
- **WB**
  - pc_we=1 for every instruction.
  - rf_we=1 for all opcodes except store, branch and suppressed (illegal).
  - Go to FETCH.
  - instret increments on WB exit unless suppressed; store retire increments it in MEM.
- **Wait counter.** Clears on entry to FETCH or MEM and counts waiting cycles. Timeout fires when the count reaches TIMEOUT-1 with ready still low.
  - Ready arriving in the same cycle as the timeout wins: normal completion, no bus_err.
- **Cycle counts** with zero-wait memory:
  - ALU, branch, jal, jalr, lui: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- **Counter wrap.** instret wraps modulo 2^CNT_W.
- **Ready outside a request.** imem_ready or dmem_ready high while the matching request is low is ignored.

Test Plan:
- rst=1 for 2 cycles, then opcode=0110011 with imem_ready tied 1 -> state sequence 0,1,2,4,0; ir_we high in cycle 0, rf_we and pc_we high in cycle 3; instret=1.
- Load (0000011), imem_ready=1, dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req=1 and dmem_we=0, then WB with rf_we=1; 8 cycles total.
- Store (0100011), dmem_ready=1 -> dmem_we=1 and pc_we=1 in the MEM cycle, rf_we never high; back in FETCH after 4 cycles; instret +1.
- Branch 1100011 and illegal 0000000 -> branch: pc_we=1, rf_we=0. Illegal: illegal pulses once, rf_we=0, instret unchanged.
- TIMEOUT=16, imem_ready held 0 -> bus_err pulses every 16 cycles, state stays 0, pc_we never high. Then dmem_ready=0 during a load -> bus_err, pc_we=1 with the return to FETCH, no rf_we, instret unchanged.
- rst asserted during MEM of a store -> next cycle state=0, dmem_req=0, instret=0. With CNT_W=4, 16 ALU instructions -> instret wraps to 0.
